// File: rtl/iccm_port_arbiter.sv
// rtl/iccm_port_arbiter.sv - ICCM port arbiter: UART loader writes vs TL-UL adapter reads
// Optional programmer idle timeout: define ICCM_PROG_TIMEOUT_EN.
module iccm_port_arbiter #(
  parameter int unsigned AW            = 12,
  parameter int unsigned DW            = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          prog_we_i,
  input  logic [AW-1:0] prog_addr_i,
  input  logic [DW-1:0] prog_wdata_i,
  input  logic          prog_done_i,
  input  logic          bus_req_i,
  input  logic [AW-1:0] bus_addr_i,
  output logic          bus_gnt_o,
  output logic [DW-1:0] bus_rdata_o,
  output logic          bus_rvalid_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_rvalid_i,
  output logic          core_hold_o,
  output logic [AW:0]   prog_count_o
);

  typedef enum logic [1:0] {BOOT, PROG, DRAIN, RUN} state_e;

  localparam logic [AW:0] CountMax = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CountOne = {{AW{1'b0}}, 1'b1};

  state_e      state_q, state_d;
  logic        rd_pend_q, rd_pend_d;
  logic [AW:0] count_q, count_d;
  logic        grant;
  logic        rd_ret;
  logic        timeout_hit;

  // A read may be granted in the same cycle the previous one returns.
  assign grant  = (state_q == RUN) & bus_req_i & ~prog_we_i & (~rd_pend_q | mem_rvalid_i);
  assign rd_ret = rd_pend_q & mem_rvalid_i;

`ifdef ICCM_PROG_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TimeoutCycles + 1);

  logic [TW-1:0] idle_q;
  logic          prog_idle;

  assign prog_idle   = (state_q == PROG) & ~prog_we_i & ~prog_done_i;
  assign timeout_hit = prog_idle & (idle_q == TW'(TimeoutCycles - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else if (!prog_idle || timeout_hit) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TimeoutCycles;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      rd_pend_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_pend_d = grant | (rd_pend_q & ~mem_rvalid_i);

    // A loader write out of RUN starts a fresh image.
    if (prog_we_i) begin
      if (state_q == RUN) begin
        count_d = CountOne;
      end else if (count_q != CountMax) begin
        count_d = count_q + CountOne;
      end
    end

    unique case (state_q)
      BOOT: begin
        if (prog_done_i) begin
          state_d = RUN;
        end else if (prog_we_i) begin
          state_d = PROG;
        end
      end
      PROG: begin
        if (prog_done_i || timeout_hit) begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (!rd_pend_q || mem_rvalid_i) begin
          state_d = PROG;
        end
      end
      RUN: begin
        if (prog_we_i) begin
          state_d = rd_pend_q ? DRAIN : PROG;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Memory and bus strobes are forced low while reset is asserted.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    bus_gnt_o    = 1'b0;
    bus_rvalid_o = 1'b0;
    bus_rdata_o  = '0;
    core_hold_o  = (state_q != RUN);
    prog_count_o = count_q;
    if (!reset) begin
      mem_req_o    = prog_we_i | grant;
      mem_we_o     = prog_we_i;
      mem_addr_o   = prog_we_i ? prog_addr_i : bus_addr_i;
      mem_wdata_o  = prog_we_i ? prog_wdata_i : '0;
      bus_gnt_o    = grant;
      bus_rvalid_o = rd_ret;
      bus_rdata_o  = rd_ret ? mem_rdata_i : '0;
    end
  end

endmodule

// File: doc/iccm_port_arbiter.md
ICCM_PORT_ARBITER -- requirements
Module: iccm_port_arbiter

Interface
REQ-001 Parameter AW, 12, ICCM word-address width.
REQ-002 Parameter DW, 32, ICCM data width.
REQ-003 Parameter TimeoutCycles, 1024, programmer idle limit (used only with ICCM_PROG_TIMEOUT_EN).
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 prog_we_i  in  1  UART loader word-write strobe.
REQ-007 prog_addr_i  in  AW  loader word address.
REQ-008 prog_wdata_i  in  DW  loader write data.
REQ-009 prog_done_i  in  1  loader end-of-image pulse.
REQ-010 bus_req_i  in  1  TL-UL SRAM adapter read request.
REQ-011 bus_addr_i  in  AW  adapter read address.
REQ-012 bus_gnt_o  out  1  adapter request accepted this cycle.
REQ-013 bus_rdata_o  out  DW  read data to adapter.
REQ-014 bus_rvalid_o  out  1  read data valid to adapter.
REQ-015 mem_req_o, mem_we_o  out  1 each  ICCM access strobe, write enable.
REQ-016 mem_addr_o  out  AW; mem_wdata_o  out  DW  ICCM address, write data.
REQ-017 mem_rdata_i  in  DW; mem_rvalid_i  in  1  ICCM read return, exactly 1 cycle after a read mem_req_o.
REQ-018 core_hold_o  out  1  holds core/fabric in reset while high.
REQ-019 prog_count_o  out  AW+1  words written in current image.

Function
REQ-020 States SHALL be BOOT, PROG, DRAIN, RUN; reset state BOOT.
REQ-021 BOOT: core_hold_o=1, bus_gnt_o=0; prog_we_i -> PROG (that write performed); prog_done_i -> RUN.
REQ-022 PROG: each prog_we_i SHALL issue mem_req_o=1, mem_we_o=1 with prog address/data the same cycle (combinational pass-through), and increment prog_count_o, saturating at 2^AW.
REQ-023 PROG: prog_done_i -> RUN next cycle; prog_we_i and prog_done_i in the same cycle: write performed, then RUN.
REQ-024 RUN: core_hold_o=0; bus_req_i SHALL give bus_gnt_o=1 and a read mem_req_o the same cycle, bus_addr_i passed through.
REQ-025 RUN: prog_we_i SHALL win over bus_req_i (bus_gnt_o=0 that cycle), assert core_hold_o next cycle, clear prog_count_o to 1, and enter DRAIN if a read is outstanding, else PROG.
REQ-026 DRAIN: core_hold_o=1, bus_gnt_o=0; loader writes still performed and counted; on mem_rvalid_i -> PROG.
REQ-027 At most one read SHALL be outstanding; bus_gnt_o=0 while one is outstanding and mem_rvalid_i not returning this cycle.
REQ-028 bus_rvalid_o SHALL equal mem_rvalid_i qualified by an outstanding read; bus_rdata_o=mem_rdata_i when valid, else 0.
REQ-029 mem_rvalid_i with no outstanding read SHALL be ignored.
REQ-030 bus_req_i outside RUN SHALL be neither granted nor dropped state-wise (no side effects).

Reset
REQ-031 Asserting reset, including mid-PROG or with a read outstanding, SHALL asynchronously force BOOT, core_hold_o=1, prog_count_o=0, outstanding flag=0, timeout counter=0.
REQ-032 During reset all mem_* and bus_* outputs SHALL be 0.

Configuration
REQ-033 With ICCM_PROG_TIMEOUT_EN defined: an idle counter SHALL clear on every prog_we_i and, after TimeoutCycles consecutive PROG cycles without prog_we_i or prog_done_i, force RUN as if prog_done_i.
REQ-034 Without ICCM_PROG_TIMEOUT_EN: no counter is built; PROG exits only via prog_done_i or reset.

Verification
REQ-035 Reset, pulse prog_done_i -> RUN, core_hold_o=0; bus_req_i addr 0x010 -> bus_gnt_o=1 same cycle, bus_rvalid_o with mem_rdata_i one cycle later.
REQ-036 Four loader writes addr 0..3 data 0xA5A5_0000+n, then prog_done_i -> four ICCM writes, prog_count_o=4, RUN next cycle.
REQ-037 In RUN, prog_we_i and bus_req_i same cycle -> write to ICCM, bus_gnt_o=0, core_hold_o=1 next cycle, prog_count_o=1.
REQ-038 Read granted, prog_we_i next cycle -> DRAIN until mem_rvalid_i, bus_rvalid_o=1 for that read, then PROG.
REQ-039 Reset asserted mid-PROG with prog_count_o=7 -> BOOT, prog_count_o=0, mem_req_o=0 immediately.
REQ-040 ICCM_PROG_TIMEOUT_EN, TimeoutCycles=16: one write then 16 idle cycles -> RUN, core_hold_o=0; without macro -> remains PROG.
